ex_hazard_ctrl: RTL and testbench



---
 rtl/ex_hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: tracks EX/MEM destinations, registers operand and flag selects, inserts load-use bubbles.
// Optional stall statistics counter enabled by defining HAZ_STATS_EN.
module ex_hazard_ctrl #(
  parameter int REG_W = 3
`ifdef HAZ_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             id_imm,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_wb,
  input  logic             id_load,
  input  logic             id_flag_rst,
  input  logic             hold,
  output logic [1:0]       ALUsrc1,
  output logic [1:0]       ALUsrc2,
  output logic             flag_src,
  output logic             id_stall,
  output logic             ex_bubble
`ifdef HAZ_STATS_EN
  , output logic [STAT_W-1:0] stall_count
`endif
);

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_IMM = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;
  localparam logic [1:0] SEL_MEM = 2'b11;

  logic             ex_valid_q, ex_valid_d;
  logic [REG_W-1:0] ex_dst_q, ex_dst_d;
  logic             ex_wb_q, ex_wb_d;
  logic             ex_load_q, ex_load_d;
  logic             ex_flag_rst_q, ex_flag_rst_d;
  // MEM needs no flag-restore copy: flag_src is decided as the instruction leaves EX.
  logic             mem_valid_q, mem_valid_d;
  logic [REG_W-1:0] mem_dst_q, mem_dst_d;
  logic             mem_wb_q, mem_wb_d;
  logic [1:0]       alu_src1_q, alu_src1_d;
  logic [1:0]       alu_src2_q, alu_src2_d;
  logic             flag_src_q, flag_src_d;
  logic             ex_bubble_q, ex_bubble_d;

  logic load_use;
  logic hit1_load, hit2_load;
  logic [1:0] fwd1, fwd2;

  function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_W-1:0] src,
                                         input logic ex_ok, input logic [REG_W-1:0] ex_dst,
                                         input logic mem_ok, input logic [REG_W-1:0] mem_dst);
    fwd_sel = SEL_REG;
    if (used && ex_ok && (src == ex_dst)) begin
      fwd_sel = SEL_ALU;
    end else if (used && mem_ok && (src == mem_dst)) begin
      fwd_sel = SEL_MEM;
    end
  endfunction

  // Decode offers an instruction with id_valid; it is accepted on a rising edge only while id_stall is low.
  always_comb begin
    hit1_load = id_use1 && (id_src1 == ex_dst_q);
    hit2_load = id_use2 && !id_imm && (id_src2 == ex_dst_q);
    load_use  = id_valid && ex_valid_q && ex_load_q && ex_wb_q && (hit1_load || hit2_load);
    id_stall  = !rst && (load_use || hold);
    fwd1 = fwd_sel(id_use1, id_src1, ex_valid_q && ex_wb_q && !ex_load_q, ex_dst_q,
                   mem_valid_q && mem_wb_q, mem_dst_q);
    fwd2 = id_imm ? SEL_IMM
                  : fwd_sel(id_use2, id_src2, ex_valid_q && ex_wb_q && !ex_load_q, ex_dst_q,
                            mem_valid_q && mem_wb_q, mem_dst_q);
  end

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_dst_d      = ex_dst_q;
    ex_wb_d       = ex_wb_q;
    ex_load_d     = ex_load_q;
    ex_flag_rst_d = ex_flag_rst_q;
    mem_valid_d   = mem_valid_q;
    mem_dst_d     = mem_dst_q;
    mem_wb_d      = mem_wb_q;
    alu_src1_d    = alu_src1_q;
    alu_src2_d    = alu_src2_q;
    flag_src_d    = flag_src_q;
    ex_bubble_d   = ex_bubble_q;
    if (!hold) begin
      mem_valid_d = ex_valid_q;
      mem_dst_d   = ex_dst_q;
      mem_wb_d    = ex_wb_q;
      if (load_use) begin
        ex_valid_d    = 1'b0;
        ex_dst_d      = '0;
        ex_wb_d       = 1'b0;
        ex_load_d     = 1'b0;
        ex_flag_rst_d = 1'b0;
        alu_src1_d    = SEL_REG;
        alu_src2_d    = SEL_REG;
        flag_src_d    = 1'b0;
        ex_bubble_d   = 1'b1;
      end else begin
        ex_valid_d    = id_valid;
        ex_dst_d      = id_dst;
        ex_wb_d       = id_wb;
        ex_load_d     = id_load;
        ex_flag_rst_d = id_flag_rst;
        alu_src1_d    = fwd1;
        alu_src2_d    = fwd2;
        flag_src_d    = ex_valid_q && ex_flag_rst_q;
        ex_bubble_d   = !id_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_dst_q      <= '0;
      ex_wb_q       <= 1'b0;
      ex_load_q     <= 1'b0;
      ex_flag_rst_q <= 1'b0;
      mem_valid_q   <= 1'b0;
      mem_dst_q     <= '0;
      mem_wb_q      <= 1'b0;
      alu_src1_q    <= SEL_REG;
      alu_src2_q    <= SEL_REG;
      flag_src_q    <= 1'b0;
      ex_bubble_q   <= 1'b1;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_dst_q      <= ex_dst_d;
      ex_wb_q       <= ex_wb_d;
      ex_load_q     <= ex_load_d;
      ex_flag_rst_q <= ex_flag_rst_d;
      mem_valid_q   <= mem_valid_d;
      mem_dst_q     <= mem_dst_d;
      mem_wb_q      <= mem_wb_d;
      alu_src1_q    <= alu_src1_d;
      alu_src2_q    <= alu_src2_d;
      flag_src_q    <= flag_src_d;
      ex_bubble_q   <= ex_bubble_d;
    end
  end

  assign ALUsrc1   = alu_src1_q;
  assign ALUsrc2   = alu_src2_q;
  assign flag_src  = flag_src_q;
  assign ex_bubble = ex_bubble_q;

`ifdef HAZ_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!hold && load_use && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed hazard scenarios then random traffic against an in-flight instruction model.
module tb_ex_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_src1, id_src2, id_dst;
  logic       id_use1, id_use2, id_imm, id_wb, id_load, id_flag_rst;
  logic       hold;
  logic [1:0] ALUsrc1, ALUsrc2;
  logic       flag_src, id_stall, ex_bubble;
`ifdef HAZ_STATS_EN
  logic [15:0] stall_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  ex_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
    .id_imm(id_imm), .id_dst(id_dst), .id_wb(id_wb), .id_load(id_load),
    .id_flag_rst(id_flag_rst), .hold(hold),
    .ALUsrc1(ALUsrc1), .ALUsrc2(ALUsrc2), .flag_src(flag_src),
    .id_stall(id_stall), .ex_bubble(ex_bubble)
`ifdef HAZ_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: instructions in flight, index 0 executing, index 1 in memory stage
  typedef struct packed {
    logic       v;
    logic [2:0] d;
    logic       wb;
    logic       ld;
    logic       fr;
  } instr_t;

  instr_t     flight[2];
  logic [1:0] exp_s1, exp_s2;
  logic       exp_flag, exp_bub;
  logic [15:0] exp_cnt;
  logic       last_stall;

  // newest producer whose result exists wins; a load still executing has no result yet
  function automatic logic [1:0] ref_fwd(input logic used, input logic [2:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (used) begin
      for (int age = 1; age >= 0; age--) begin
        if (flight[age].v && flight[age].wb && flight[age].d == src && !(age == 0 && flight[age].ld))
          sel = (age == 0) ? 2'b10 : 2'b11;
      end
    end
    return sel;
  endfunction

  function automatic logic ref_load_use();
    logic dep;
    dep = (id_use1 && id_src1 == flight[0].d) || (id_use2 && !id_imm && id_src2 == flight[0].d);
    return id_valid && flight[0].v && flight[0].ld && flight[0].wb && dep;
  endfunction

  task automatic ref_clock();
    logic lu;
    lu = ref_load_use();
    if (rst) begin
      flight[0] = '0; flight[1] = '0;
      exp_s1 = 2'b00; exp_s2 = 2'b00; exp_flag = 1'b0; exp_bub = 1'b1; exp_cnt = 16'd0;
    end else if (hold) begin
      // frozen
    end else if (lu) begin
      flight[1] = flight[0];
      flight[0] = '0;
      exp_s1 = 2'b00; exp_s2 = 2'b00; exp_flag = 1'b0; exp_bub = 1'b1;
      if (exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'd1;
    end else begin
      exp_s1   = ref_fwd(id_use1, id_src1);
      exp_s2   = id_imm ? 2'b01 : ref_fwd(id_use2, id_src2);
      exp_flag = flight[0].v && flight[0].fr;
      exp_bub  = !id_valid;
      flight[1] = flight[0];
      flight[0] = '{v: id_valid, d: id_dst, wb: id_wb, ld: id_load, fr: id_flag_rst};
    end
  endtask

  // scoreboard comparison
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: one clock cycle with the given decode/hold/reset inputs
  task automatic step(input logic v, input logic [2:0] s1, input logic u1,
                      input logic [2:0] s2, input logic u2, input logic imm,
                      input logic [2:0] d, input logic wb, input logic ld, input logic fr,
                      input logic hd, input logic r);
    @(negedge clk);
    id_valid = v; id_src1 = s1; id_use1 = u1; id_src2 = s2; id_use2 = u2; id_imm = imm;
    id_dst = d; id_wb = wb; id_load = ld; id_flag_rst = fr; hold = hd; rst = r;
    #1;
    last_stall = id_stall;
    check("id_stall", {15'd0, id_stall}, {15'd0, !r && (ref_load_use() || hd)});
    @(posedge clk);
    ref_clock();
    #1;
    check("ALUsrc1", {14'd0, ALUsrc1}, {14'd0, exp_s1});
    check("ALUsrc2", {14'd0, ALUsrc2}, {14'd0, exp_s2});
    check("flag_src", {15'd0, flag_src}, {15'd0, exp_flag});
    check("ex_bubble", {15'd0, ex_bubble}, {15'd0, exp_bub});
`ifdef HAZ_STATS_EN
    check("stall_count", stall_count, exp_cnt);
`endif
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    flight[0] = '0; flight[1] = '0;
    exp_s1 = 2'b00; exp_s2 = 2'b00; exp_flag = 1'b0; exp_bub = 1'b1; exp_cnt = 16'd0;
    last_stall = 1'b0;
    rst = 1'b1; hold = 1'b0; id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_dst = '0;
    id_use1 = 1'b0; id_use2 = 1'b0; id_imm = 1'b0; id_wb = 1'b0; id_load = 1'b0; id_flag_rst = 1'b0;

    // reset, including hold asserted during reset
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 1, 1, 1, 0, 1, 1, 0, 0, 1, 1);
    check("rst_stall", {15'd0, last_stall}, 16'd0);
    check("rst_bubble", {15'd0, ex_bubble}, 16'd1);
    check("rst_sel1", {14'd0, ALUsrc1}, 16'd0);
    nop(); nop();

    // back-to-back ALU dependency
    step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    check("b2b_stall", {15'd0, last_stall}, 16'd0);
    check("b2b_sel1", {14'd0, ALUsrc1}, 16'd2);
    nop(); nop();

    // distance-2 dependency on operand 2
    step(1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    step(1, 0, 0, 2, 1, 0, 6, 0, 0, 0, 0, 0);
    check("dist2_sel2", {14'd0, ALUsrc2}, 16'd3);
    nop(); nop();

    // load-use: exactly one bubble then memory forwarding
    step(1, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
    step(1, 3, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    check("lu_stall", {15'd0, last_stall}, 16'd1);
    check("lu_bubble", {15'd0, ex_bubble}, 16'd1);
    step(1, 3, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    check("lu_nostall", {15'd0, last_stall}, 16'd0);
    check("lu_sel1", {14'd0, ALUsrc1}, 16'd3);
    check("lu_valid", {15'd0, ex_bubble}, 16'd0);
    nop(); nop();

    // immediate beats forwarding
    step(1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
    step(1, 0, 0, 4, 1, 1, 1, 0, 0, 0, 0, 0);
    check("imm_sel2", {14'd0, ALUsrc2}, 16'd1);
    nop(); nop();

    // flag restore instruction reaching memory
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("flag_set", {15'd0, flag_src}, 16'd1);
    nop();
    check("flag_clr", {15'd0, flag_src}, 16'd0);
    nop();

    // hold over a pending load-use
    step(1, 0, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 6, 1, 0, 0, 0, 2, 1, 0, 0, 1, 0);
      check("hold_frozen", {15'd0, ex_bubble}, 16'd0);
    end
    step(1, 6, 1, 0, 0, 0, 2, 1, 0, 0, 0, 0);
    check("hold_lu_stall", {15'd0, last_stall}, 16'd1);
    check("hold_bubble", {15'd0, ex_bubble}, 16'd1);
    step(1, 6, 1, 0, 0, 0, 2, 1, 0, 0, 0, 0);
    check("hold_sel1", {14'd0, ALUsrc1}, 16'd3);
    nop(); nop();

    // reset in the middle of a load-use stall
    step(1, 0, 0, 0, 0, 0, 7, 1, 1, 1, 0, 0);
    step(1, 7, 1, 7, 1, 0, 3, 1, 0, 0, 0, 1);
    check("mid_rst_stall", {15'd0, last_stall}, 16'd0);
    check("mid_rst_bubble", {15'd0, ex_bubble}, 16'd1);
    check("mid_rst_sel2", {14'd0, ALUsrc2}, 16'd0);
`ifdef HAZ_STATS_EN
    check("mid_rst_count", stall_count, 16'd0);
`endif

    // random traffic on a narrow register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 4) != 0),
           3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           3'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
